ps2_scancode_queue: RTL and testbench
=====================================

Name: ps2_scancode_queue

Overview:
- Sits between PS2_Interface and processor. Consumes the raw scan-code byte stream (ps2_out / ps2_key_pressed).
- Folds set-2 prefix bytes (E0 extended, F0 break) into single key events. Buffers events in a first-word-fall-through FIFO so the processor can pop them at its own pace without losing keystrokes.
- Also exposes sticky overflow and protocol-error flags for debug_word or LEDs.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- DROP_BREAK, 0, when 1 break events are decoded but never pushed.

Ports:
- clock  in  1  system clock (same clock as processor and PS2_Interface)
- reset  in  1  asynchronous, active-high reset (top level drives ~resetn)
- key_valid  in  1  byte-ready level from PS2_Interface (ps2_key_pressed); may stay high several cycles
- key_data  in  8  received byte (ps2_out)
- pop  in  1  processor consumes head entry
- clear  in  1  synchronous flush
- rd_data  out  10  head entry {is_break, is_ext, code[7:0]}
- rd_valid  out  1  FIFO non-empty
- count  out  ADDR_W+1  entries held, 0..DEPTH
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- proto_err  out  1  sticky: illegal prefix sequence or 0x00/0xFF byte seen

Behaviour:
- Reset, asynchronous: FSM to IDLE; pointers and count to 0; rd_valid=0, rd_data=0, overflow=0, proto_err=0; edge-detect register (key_prev) to 0.
- Byte acceptance: a byte is accepted on a clock edge where key_valid=1 and key_prev=0. key_prev <= key_valid every cycle. A held-high key_valid yields exactly one acceptance.
- Decoder FSM transitions on accepted bytes only (b = key_data):
  - IDLE:
    - b=E0 -> EXT
    - b=F0 -> BRK
    - b=00/FF -> proto_err<=1, stay
    - otherwise push {0,0,b}
  - EXT:
    - b=F0 -> EXT_BRK
    - b=E0 -> stay EXT
    - b=00/FF -> proto_err<=1, -> IDLE
    - otherwise push {0,1,b}, -> IDLE
  - BRK:
    - b=E0/F0/00/FF -> proto_err<=1, -> IDLE, no push
    - otherwise push {1,0,b}, -> IDLE
  - EXT_BRK:
    - b=E0/F0/00/FF -> proto_err<=1, -> IDLE, no push
    - otherwise push {1,1,b}, -> IDLE
- DROP_BREAK=1: pushes with is_break=1 are suppressed; FSM transitions are unchanged.
- FIFO is first-word fall-through:
  - rd_data reflects the head entry whenever rd_valid=1; rd_data=0 when empty.
  - Latency: the event is visible on rd_data/rd_valid in the cycle after the edge that accepted its final byte.
- pop with rd_valid=1 removes the head at the clock edge. pop while empty is ignored: no underflow, count stays 0.
- Push when count=DEPTH and no pop: event dropped, overflow<=1, FIFO contents unchanged.
- Push and pop on the same edge:
  - When full: both occur, count stays DEPTH, no overflow.
  - When empty: pop ignored, push occurs, count=1.
- Pointers wrap modulo DEPTH. count changes by +1, -1 or 0 per edge and never leaves 0..DEPTH.
- clear (synchronous) has priority over push and pop in the same cycle:
  - empties the FIFO and clears overflow and proto_err;
  - returns the FSM to IDLE;
  - does not change key_prev, so a byte still held on key_valid is not re-accepted.
- Reset asserted mid-sequence (for example after E0): partial prefix discarded and the FIFO emptied.
- overflow and proto_err stay set until clear or reset.

Test Plan:
- Make code: key_valid high for 3 cycles with 1C -> exactly one entry, rd_data=0x01C, count=1. pop -> rd_valid=0, count=0.
- Extended break: bytes E0,F0,74, each a separate key_valid pulse -> single entry rd_data=0x374, count=1, proto_err=0.
- Fill and overflow (DEPTH=16): 17 make codes 0x10..0x20 without pop -> count=16, overflow=1, head=0x010. 16 pops return 0x010..0x01F in order, then rd_valid=0.
- Simultaneous push and pop at full: code 0x2A accepted on the same edge as pop -> count stays 16, overflow unchanged, new tail=0x02A, head advances to 0x011.
- Protocol errors: F0 then F0 -> proto_err=1, no push. Then 00 in IDLE -> no push. Then clear with a concurrent byte 0x15 accepted -> count=0, proto_err=0, FSM IDLE, 0x15 not queued.
- DROP_BREAK=1 and async reset: bytes 1C,F0,1C -> only 0x01C queued. Then E0 followed by an async reset pulse, then 75 -> single entry 0x075, is_ext=0.

Source files
------------

// File: rtl/ps2_scancode_queue.sv
// PS/2 set-2 scan-code folder and first-word-fall-through event queue.
// Turns E0/F0 prefixed byte runs into {is_break, is_ext, code} entries.
module ps2_scancode_queue #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter bit DROP_BREAK = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [7:0]        key_data,
    input  logic              pop,
    input  logic              clear,
    output logic [9:0]        rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_key_prev;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;
    logic                r_proto_err;
    logic [9:0]          r_mem [DEPTH];

    logic                w_accept;
    logic                w_is_e0;
    logic                w_is_f0;
    logic                w_bad;
    logic                w_push;
    logic                w_push_q;
    logic                w_perr;
    logic [9:0]          w_entry;
    logic                w_empty;
    logic                w_full;
    logic                w_do_pop;
    logic                w_do_push;
    logic                w_ovf;

    assign w_accept = key_valid & ~r_key_prev;
    assign w_is_e0  = (key_data == 8'hE0);
    assign w_is_f0  = (key_data == 8'hF0);
    assign w_bad    = (key_data == 8'h00) | (key_data == 8'hFF);

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr      = 1'b0;
        w_entry     = 10'd0;
        if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_is_e0) begin
                        w_state_nxt = S_EXT;
                    end else if (w_is_f0) begin
                        w_state_nxt = S_BRK;
                    end else if (w_bad) begin
                        w_perr = 1'b1;
                    end else begin
                        w_push  = 1'b1;
                        w_entry = {2'b00, key_data};
                    end
                end
                S_EXT: begin
                    if (w_is_f0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (w_is_e0) begin
                        w_state_nxt = S_EXT;
                    end else if (w_bad) begin
                        w_perr      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_push      = 1'b1;
                        w_entry     = {2'b01, key_data};
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_state_nxt = S_IDLE;
                    if (w_is_e0 | w_is_f0 | w_bad) begin
                        w_perr = 1'b1;
                    end else begin
                        w_push  = 1'b1;
                        w_entry = {2'b10, key_data};
                    end
                end
                S_EXT_BRK: begin
                    w_state_nxt = S_IDLE;
                    if (w_is_e0 | w_is_f0 | w_bad) begin
                        w_perr = 1'b1;
                    end else begin
                        w_push  = 1'b1;
                        w_entry = {2'b11, key_data};
                    end
                end
            endcase
        end
    end

    // Break events still walk the FSM; only the enqueue is suppressed.
    assign w_push_q  = w_push & ~(DROP_BREAK & w_entry[9]);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL);
    assign w_do_pop  = pop & ~w_empty;
    assign w_do_push = w_push_q & (~w_full | w_do_pop);
    assign w_ovf     = w_push_q & w_full & ~w_do_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_key_prev  <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_key_prev <= key_valid;
            if (clear) begin
                r_state     <= S_IDLE;
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_proto_err <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (w_do_push) r_wptr <= r_wptr + ADDR_W'(1);
                if (w_do_pop)  r_rptr <= r_rptr + ADDR_W'(1);
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_ovf)  r_overflow  <= 1'b1;
                if (w_perr) r_proto_err <= 1'b1;
            end
        end
    end

    // On a full push+pop the write slot is the head being popped.
    always_ff @(posedge clock) begin
        if (w_do_push && !clear) r_mem[r_wptr] <= w_entry;
    end

    assign rd_valid  = ~w_empty;
    assign rd_data   = w_empty ? 10'd0 : r_mem[r_rptr];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_ps2_scancode_queue.sv
// Bench for ps2_scancode_queue: directed plan plus randomized byte streams
// against a prefix-flag/queue reference model.
module tb_ps2_scancode_queue;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, kv, pop, clr;
    logic [7:0] kd;
    logic [9:0] rd_data;
    logic       rd_valid, ovf, perr;
    logic [4:0] cnt;

    logic       rst2, kv2, pop2, clr2;
    logic [7:0] kd2;
    logic [9:0] rd_data2;
    logic       rd_valid2, ovf2, perr2;
    logic [4:0] cnt2;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [9:0] q[$];
    bit m_ext, m_brk, m_ovf, m_perr, m_prev;

    always #5 clk = ~clk;

    ps2_scancode_queue #(.DEPTH(16), .ADDR_W(4), .DROP_BREAK(1'b0)) dut (
        .clock(clk), .reset(rst), .key_valid(kv), .key_data(kd),
        .pop(pop), .clear(clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(cnt), .overflow(ovf), .proto_err(perr)
    );

    ps2_scancode_queue #(.DEPTH(16), .ADDR_W(4), .DROP_BREAK(1'b1)) dut_db (
        .clock(clk), .reset(rst2), .key_valid(kv2), .key_data(kd2),
        .pop(pop2), .clear(clr2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .count(cnt2), .overflow(ovf2), .proto_err(perr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0; m_prev = 0;
    endtask

    // One clock edge of the specified behaviour, at a higher level.
    task automatic model_edge(input bit v, input logic [7:0] b,
                              input bit p, input bit c);
        bit acc, have, full0, popok;
        logic [9:0] ev;
        acc = v && !m_prev;
        m_prev = v;
        if (c) begin
            q.delete();
            m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0;
            return;
        end
        have = 0;
        ev = '0;
        if (acc) begin
            if (b == 8'h00 || b == 8'hFF) begin
                m_perr = 1; m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0 || b == 8'hF0) begin
                if (m_brk) begin
                    m_perr = 1; m_ext = 0; m_brk = 0;
                end else if (b == 8'hE0) m_ext = 1;
                else m_brk = 1;
            end else begin
                ev = {m_brk, m_ext, b};
                have = 1;
                m_ext = 0; m_brk = 0;
            end
        end
        full0 = (q.size() == DEPTH);
        popok = p && (q.size() > 0);
        if (popok) void'(q.pop_front());
        if (have) begin
            if (full0 && !popok) m_ovf = 1;
            else q.push_back(ev);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(rd_valid), 32'(q.size() > 0));
        chk({tag, ".data"}, 32'(rd_data), 32'(q.size() > 0 ? q[0] : 10'd0));
        chk({tag, ".count"}, 32'(cnt), 32'(q.size()));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".perr"}, 32'(perr), 32'(m_perr));
    endtask

    task automatic cyc(input bit v, input logic [7:0] b,
                       input bit p, input bit c);
        kv = v; kd = b; pop = p; clr = c;
        @(negedge clk);
        model_edge(v, b, p, c);
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        for (int i = 0; i < hold; i++) cyc(1, b, 0, 0);
        cyc(0, b, 0, 0);
    endtask

    task automatic do_pop();
        cyc(0, 8'h00, 1, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cyc2(input bit v, input logic [7:0] b);
        kv2 = v; kd2 = b; pop2 = 0; clr2 = 0;
        @(negedge clk);
    endtask

    task automatic send2(input logic [7:0] b);
        cyc2(1, b);
        cyc2(0, b);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        rst = 1; kv = 0; kd = 0; pop = 0; clr = 0;
        rst2 = 1; kv2 = 0; kd2 = 0; pop2 = 0; clr2 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0; rst2 = 0;
        @(negedge clk);
        check_all("reset");
        chk("reset.db_valid", 32'(rd_valid2), 0);

        // Held make code: single acceptance
        send(8'h1C, 3);
        chk("make.data", 32'(rd_data), 32'h01C);
        chk("make.count", 32'(cnt), 1);
        check_all("make");
        do_pop();
        chk("make_pop.valid", 32'(rd_valid), 0);
        check_all("make_pop");

        // Extended break
        send(8'hE0, 1);
        send(8'hF0, 1);
        send(8'h74, 1);
        chk("extbrk.data", 32'(rd_data), 32'h374);
        check_all("extbrk");
        do_pop();

        // Fill and overflow
        for (int i = 0; i < 17; i++) send(8'(8'h10 + i), 1);
        chk("fill.count", 32'(cnt), 16);
        chk("fill.ovf", 32'(ovf), 1);
        chk("fill.head", 32'(rd_data), 32'h010);
        check_all("fill");

        // Push and pop on the same edge while full
        cyc(1, 8'h2A, 1, 0);
        cyc(0, 8'h2A, 0, 0);
        chk("pp.count", 32'(cnt), 16);
        chk("pp.head", 32'(rd_data), 32'h011);
        check_all("pp");
        for (int i = 0; i < 16; i++) begin
            do_pop();
            check_all("drain");
        end
        chk("drain.valid", 32'(rd_valid), 0);
        do_pop();
        chk("underflow.count", 32'(cnt), 0);

        // Protocol errors and clear with a concurrent byte
        cyc(0, 8'h00, 0, 1);
        send(8'hF0, 1);
        send(8'hF0, 1);
        chk("ff.perr", 32'(perr), 1);
        check_all("ff");
        send(8'h00, 1);
        check_all("zero");
        cyc(1, 8'h15, 0, 1);
        cyc(1, 8'h15, 0, 0);
        cyc(0, 8'h15, 0, 0);
        chk("clr.count", 32'(cnt), 0);
        chk("clr.perr", 32'(perr), 0);
        check_all("clr");
        send(8'h1C, 1);
        chk("clr.idle", 32'(rd_data), 32'h01C);
        do_pop();

        // Reset mid-prefix
        send(8'hE0, 1);
        pulse_reset();
        @(negedge clk);
        send(8'h75, 1);
        chk("rstmid.data", 32'(rd_data), 32'h075);
        check_all("rstmid");

        // Randomized streams
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 33) b = 8'h00;
            else if (r < 36) b = 8'hFF;
            else             b = 8'($urandom_range(0, 255));
            cyc(1, b, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) cyc(1, b, 0, 0);
            cyc(0, b, $urandom_range(0, 99) < 30, 0);
            check_all("rand");
        end

        // DROP_BREAK instance
        send2(8'h1C);
        send2(8'hF0);
        send2(8'h1C);
        chk("db.count", 32'(cnt2), 1);
        chk("db.data", 32'(rd_data2), 32'h01C);
        chk("db.perr", 32'(perr2), 0);
        send2(8'hE0);
        rst2 = 1'b1;
        #2;
        rst2 = 1'b0;
        chk("db.rst_count", 32'(cnt2), 0);
        @(negedge clk);
        send2(8'h75);
        chk("db.rst_data", 32'(rd_data2), 32'h075);
        chk("db.rst_cnt1", 32'(cnt2), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
